serial_sub: RTL and testbench
=============================

# serial_sub

Bit-serial unsigned subtractor that streams a WIDTH-bit operand pair LSB-first through a single full-subtract cell, one bit per clock, with a registered borrow. It sits directly upstream of the full-subtractor cell in the arithmetic path. It owns operand capture, sequencing and the borrow chain, and presents a parallel difference plus final borrow with a start/busy/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits (≥2).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  initial borrow-in; present only with SERIAL_SUB_BIN_EN.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse when diff/bout become valid.
- diff  output  WIDTH  (a − b − bin) mod 2^WIDTH.
- bout  output  1  final borrow: 1 iff a < b + bin (unsigned).

## Operation
- States: IDLE, SHIFT, DONE. Bit counter: ceil(log2(WIDTH+1)) bits.
- IDLE, start=1 → SHIFT:
  - Load shift registers sa←a and sb←b.
  - Load borrow register br←bin (br←0 without the macro).
  - Clear count; busy←1.
- SHIFT, each edge:
  - d = sa[0]^sb[0]^br.
  - br ← (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br).
  - Shift sa and sb right by one.
  - Shift d into the MSB of the result register (right shift), so bit 0 ends at diff[0].
  - count += 1.
  - When the edge processes bit WIDTH−1 → DONE.
- DONE, held for one cycle:
  - done=1, busy=0.
  - diff = result register; bout = br.
  - Next edge → IDLE, or → SHIFT if start=1 (a new request is accepted in DONE).
- diff and bout hold their last values until the next DONE. The result register is separate from the output register, so outputs do not ripple during SHIFT.
- start while busy=1 is ignored. a, b and bin may change freely after the accepting edge.
- Reset (any state, including mid-SHIFT):
  - Immediately: state=IDLE, busy=0, done=0, diff=0, bout=0, br=0, count=0.
  - The aborted operation produces no done.

## Timing
- Edge E0 samples start=1: busy=1 after E0.
- Bits 0..WIDTH−1 are processed on edges E1..EWIDTH.
- After EWIDTH: done=1, diff/bout valid, busy=0.
- After EWIDTH+1: done=0.
- Latency from the start edge to the done pulse: WIDTH cycles.
- Throughput: one operation per WIDTH+1 cycles, including back-to-back start in DONE.
- All outputs are registered. No combinational path from inputs to outputs.
- Reset deassertion: the first accepting edge is the first rising clk edge with rst=0.

## Configuration
- SERIAL_SUB_BIN_EN defined:
  - The bin port exists and seeds br at the accepting edge.
  - The block can be chained for multi-word subtraction.
- Not defined:
  - No bin port; br is seeded with 0.
  - diff = (a − b) mod 2^WIDTH, bout = (a < b).
- Handshake, latency and state machine are identical in both builds.

## Test plan
All scenarios use WIDTH=8.
- Reset release, then a=0x10, b=0x01, start for 1 cycle → busy high 8 cycles, done pulse exactly 8 cycles after the start edge; diff=0x0F, bout=0.
- a=0x00, b=0x01 → diff=0xFF, bout=1. Also a=0x5A, b=0x5A → diff=0x00, bout=0.
- start held high continuously with operands changing each cycle:
  - Only operands sampled in IDLE/DONE are used.
  - Done pulses every 9 cycles.
  - Each result matches the operands captured at its own accepting edge.
- Assert rst at cycle 4 of SHIFT:
  - busy, done, diff and bout go 0 immediately (asynchronous).
  - No done appears afterwards.
  - The next operation 0x80−0x7F gives diff=0x01, bout=0.
- With SERIAL_SUB_BIN_EN, bin=1: a=0x05, b=0x05 → diff=0xFF, bout=1; a=0x06, b=0x05 → diff=0x00, bout=0.
- Randomized pairs (≥1000) against reference model a−b−bin → diff/bout exact match. Assert done is never high while busy=1.

Source files
------------

// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned subtractor.
// Streams a WIDTH-bit operand pair LSB-first through one full-subtract cell,
// one bit per clock, with a registered borrow. Start/busy/done handshake,
// parallel registered difference and final borrow.
// Optional feature macro: SERIAL_SUB_BIN_EN adds the bin port that seeds the
// borrow chain (for chaining multi-word subtractions); without it the borrow
// chain is seeded with 0.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BIN_EN
  input  logic             bin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One full-subtract cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] fsub_cell(input logic x, input logic y, input logic bi);
    logic d;
    logic bo;
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
    return {bo, d};
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] res_r;
  logic             br_r;
  logic [CW-1:0]    count_r;

  logic [1:0]       cell_s;
  logic [WIDTH-1:0] res_next_s;
  logic             bin_seed_s;

`ifdef SERIAL_SUB_BIN_EN
  assign bin_seed_s = bin;
`else
  assign bin_seed_s = 1'b0;
`endif

  // Current bit through the subtract cell and the result register after shifting it in.
  always_comb begin
    cell_s     = fsub_cell(sa_r[0], sb_r[0], br_r);
    res_next_s = {cell_s[0], res_r[WIDTH-1:1]};
  end

  // Sequencer: operand capture, bit-serial borrow chain and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sa_r    <= '0;
      sb_r    <= '0;
      res_r   <= '0;
      br_r    <= 1'b0;
      count_r <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          // A new request is accepted in DONE as well, giving WIDTH+1 cycle throughput.
          done <= 1'b0;
          if (start) begin
            sa_r    <= a;
            sb_r    <= b;
            br_r    <= bin_seed_s;
            count_r <= '0;
            busy    <= 1'b1;
            state_r <= ST_SHIFT;
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          sa_r    <= sa_r >> 1;
          sb_r    <= sb_r >> 1;
          br_r    <= cell_s[1];
          res_r   <= res_next_s;
          count_r <= count_r + CW'(1);
          if (count_r == LAST_BIT) begin
            // Outputs take the final values on the same edge, so done/diff/bout appear together.
            diff    <= res_next_s;
            bout    <= cell_s[1];
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            busy    <= 1'b1;
            state_r <= ST_SHIFT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8) with a behavioural reference model.
module tb_serial_sub;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin_v;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int checks = 0;
  int passes = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_SUB_BIN_EN
    .bin   (bin_v),
`endif
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain wide arithmetic on the operands, {bout, diff}.
  function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic bi);
    logic [31:0] t;
    logic        bo;
    logic        eff_bi;
`ifdef SERIAL_SUB_BIN_EN
    eff_bi = bi;
`else
    eff_bi = 1'b0;
`endif
    t  = {24'd0, x} - {24'd0, y} - {31'd0, eff_bi};
    bo = ({24'd0, x} < ({24'd0, y} + {31'd0, eff_bi}));
    return {bo, t[7:0]};
  endfunction

  // Monitor: done must never coincide with busy.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (busy) $display("FAIL done_busy_overlap: busy=%0b while done=1, required busy=0", busy);
      else passes++;
    end
  end

  // Drive one request and wait for done; reports latency and busy-cycle count.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic bi,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    a = x; b = y; bin_v = bi; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin_v = 1'($urandom);
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
    end
    if (lat == 0) begin
      checks++;
      $display("FAIL op_timeout: no done within 20 cycles, required done");
    end
  endtask

  task automatic check_result(input string name, input logic [7:0] x, input logic [7:0] y,
                              input logic bi);
    logic [8:0] exp;
    exp = ref_sub(x, y, bi);
    checks++;
    if ({bout, diff} !== exp)
      $display("FAIL %s: a=%h b=%h bin=%0b got bout=%0b diff=%h required bout=%0b diff=%h",
               name, x, y, bi, bout, diff, exp[8], exp[7:0]);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; bin_v = 1'b0;
    #12;
    checks++;
    if ({busy, done, diff, bout} !== 11'd0)
      $display("FAIL reset_state: got busy=%0b done=%0b diff=%h bout=%0b required all 0",
               busy, done, diff, bout);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bc;
    run_op(8'h10, 8'h01, 1'b0, lat, bc);
    checks++;
    if (lat !== 8) $display("FAIL basic_latency: got %0d required 8", lat);
    else passes++;
    checks++;
    if (bc !== 8) $display("FAIL basic_busy_cycles: got %0d required 8", bc);
    else passes++;
    checks++;
    if ({bout, diff} !== 9'h00F) $display("FAIL basic_result: got bout=%0b diff=%h required bout=0 diff=0f", bout, diff);
    else passes++;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0) $display("FAIL done_one_cycle: got done=%0b required 0", done);
    else passes++;
    checks++;
    if (diff !== 8'h0F) $display("FAIL diff_hold: got %h required 0f", diff);
    else passes++;
  endtask

  task automatic test_boundaries();
    int lat, bc;
    run_op(8'h00, 8'h01, 1'b0, lat, bc);
    checks++;
    if ({bout, diff} !== 9'h1FF) $display("FAIL underflow: got bout=%0b diff=%h required bout=1 diff=ff", bout, diff);
    else passes++;
    run_op(8'h5A, 8'h5A, 1'b0, lat, bc);
    checks++;
    if ({bout, diff} !== 9'h000) $display("FAIL equal_operands: got bout=%0b diff=%h required bout=0 diff=00", bout, diff);
    else passes++;
    run_op(8'hFF, 8'h00, 1'b0, lat, bc);
    check_result("max_minus_zero", 8'hFF, 8'h00, 1'b0);
`ifdef SERIAL_SUB_BIN_EN
    run_op(8'h05, 8'h05, 1'b1, lat, bc);
    checks++;
    if ({bout, diff} !== 9'h1FF) $display("FAIL bin_equal: got bout=%0b diff=%h required bout=1 diff=ff", bout, diff);
    else passes++;
    run_op(8'h06, 8'h05, 1'b1, lat, bc);
    checks++;
    if ({bout, diff} !== 9'h000) $display("FAIL bin_exact: got bout=%0b diff=%h required bout=0 diff=00", bout, diff);
    else passes++;
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic       qi[$];
    logic [7:0] ea, eb;
    logic       ei;
    logic       exp_done;
    @(negedge clk);
    start = 1'b1;
    for (int j = 0; j < 45; j++) begin
      a = 8'($urandom); b = 8'($urandom); bin_v = 1'($urandom);
      if (j % 9 == 0) begin
        qa.push_back(a); qb.push_back(b); qi.push_back(bin_v);
      end
      @(posedge clk);
      @(negedge clk);
      exp_done = (j % 9 == 8);
      checks++;
      if (done !== exp_done) $display("FAIL b2b_done_timing: edge %0d got done=%0b required %0b", j, done, exp_done);
      else passes++;
      if (exp_done && qa.size() > 0) begin
        ea = qa.pop_front(); eb = qb.pop_front(); ei = qi.pop_front();
        check_result("b2b_result", ea, eb, ei);
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    bit saw_done;
    run_op(8'hC3, 8'h21, 1'b0, lat, bc);
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, diff, bout} !== 11'd0)
      $display("FAIL async_reset: got busy=%0b done=%0b diff=%h bout=%0b required all 0",
               busy, done, diff, bout);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) $display("FAIL aborted_done: got a done pulse after reset, required none");
    else passes++;
    run_op(8'h80, 8'h7F, 1'b0, lat, bc);
    checks++;
    if ({bout, diff} !== 9'h001) $display("FAIL post_reset_op: got bout=%0b diff=%h required bout=0 diff=01", bout, diff);
    else passes++;
  endtask

  task automatic test_random();
    int lat, bc;
    logic [7:0] x, y;
    logic bi;
    for (int n = 0; n < 1000; n++) begin
      x = 8'($urandom); y = 8'($urandom); bi = 1'($urandom);
      run_op(x, y, bi, lat, bc);
      check_result("random", x, y, bi);
      checks++;
      if (lat !== 8) $display("FAIL random_latency: got %0d required 8", lat);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
